// File: rtl/adder_response_misr.sv
// Response compactor for the 4-bit ripple carry adder: folds {Cout,s3..s0} into a
// MISR over a programmed number of vectors, then compares against a golden signature.
module adder_response_misr #(
  parameter int                 SIG_W = 16,
  parameter logic [SIG_W-1:0]   POLY  = 16'h1021,
  parameter logic [SIG_W-1:0]   SEED  = 16'hFFFF,
  parameter int                 CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             in_valid,
  input  logic             s0,
  input  logic             s1,
  input  logic             s2,
  input  logic             s3,
  input  logic             Cout,
  input  logic [SIG_W-1:0] golden_sig,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic             match,
  output logic [CNT_W-1:0] vec_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] num_lat;
  logic [SIG_W-1:0] d_word;
  logic [SIG_W-1:0] sig_next;
  logic             last_vec;

  assign d_word   = SIG_W'({Cout, s3, s2, s1, s0});
  assign sig_next = {signature[SIG_W-2:0], 1'b0}
                  ^ (signature[SIG_W-1] ? POLY : '0)
                  ^ d_word;
  // num_lat is never zero in RUN, so the minus-one compare cannot underflow
  assign last_vec = (vec_count == CNT_W'(num_lat - 1'b1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      signature <= SEED;
      vec_count <= '0;
      num_lat   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      match     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            signature <= SEED;
            vec_count <= '0;
            match     <= 1'b0;
            if (num_vectors != '0) begin
              num_lat <= num_vectors;
              busy    <= 1'b1;
              state   <= RUN;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (in_valid) begin
            signature <= sig_next;
            vec_count <= vec_count + 1'b1;
            if (last_vec) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          match <= (signature == golden_sig);
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_response_misr.sv
// Directed bench for adder_response_misr: default-SEED and SEED=0 instances, hand-computed
// signatures, and a clean-vs-trojan adder response comparison.
module tb_adder_response_misr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [7:0]  num_vectors = '0;
  logic        in_valid = 1'b0;
  logic [4:0]  dv = '0;
  logic [15:0] golden_sig = '0;

  logic        busy_a, done_a, match_a, busy_b, done_b, match_b;
  logic [15:0] sig_a, sig_b;
  logic [7:0]  vc_a, vc_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_response_misr u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .num_vectors(num_vectors), .in_valid(in_valid),
    .s0(dv[0]), .s1(dv[1]), .s2(dv[2]), .s3(dv[3]), .Cout(dv[4]), .golden_sig(golden_sig),
    .busy(busy_a), .done(done_a), .signature(sig_a), .match(match_a), .vec_count(vc_a));

  adder_response_misr #(.SEED(16'h0000)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .num_vectors(num_vectors), .in_valid(in_valid),
    .s0(dv[0]), .s1(dv[1]), .s2(dv[2]), .s3(dv[3]), .Cout(dv[4]), .golden_sig(golden_sig),
    .busy(busy_b), .done(done_b), .signature(sig_b), .match(match_b), .vec_count(vc_b));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [4:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {11'b0, d};
  endfunction

  // trojan: s0 inverted whenever operand a is 4'hA
  function automatic logic [4:0] adder(input logic [3:0] a, input logic [3:0] b, input bit troj);
    logic [4:0] r;
    r = {1'b0, a} + {1'b0, b};
    if (troj && a == 4'hA) r[0] = ~r[0];
    return r;
  endfunction

  task automatic run16(input bit troj);
    logic [3:0] a, b;
    num_vectors = 8'd16; start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a = 4'(i);
      b = 4'((i * 7 + 3) & 15);
      dv = adder(a, b, troj);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("t6_done", done_a, 1'b1);
    chk("t6_vcount", vc_a, 16);
    step();
  endtask

  logic [15:0] clean_sig;

  initial begin
    // 1: reset values
    step(); step();
    chk("rst_sig_a", sig_a, 16'hFFFF);
    chk("rst_sig_b", sig_b, 16'h0000);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_match", match_a, 1'b0);
    chk("rst_vcount", vc_a, 8'd0);
    rst = 1'b0;

    // 2: single zero vector from SEED FFFF
    golden_sig = 16'hEFDF; num_vectors = 8'd1; start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("t2_busy", busy_a, 1'b1);
    dv = 5'h00; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t2_sig", sig_a, 16'hEFDF);
    chk("t2_vcount", vc_a, 8'd1);
    chk("t2_done", done_a, 1'b1);
    chk("t2_busy_off", busy_a, 1'b0);
    step();
    chk("t2_done_off", done_a, 1'b0);
    chk("t2_match", match_a, 1'b1);

    // 3: SEED 0, two vectors of 1
    golden_sig = 16'h0004; num_vectors = 8'd2; start_b = 1'b1;
    step();
    start_b = 1'b0; dv = 5'h01; in_valid = 1'b1;
    step();
    chk("t3_sig1", sig_b, 16'h0001);
    chk("t3_done_early", done_b, 1'b0);
    step();
    in_valid = 1'b0;
    chk("t3_sig2", sig_b, 16'h0003);
    chk("t3_vcount", vc_b, 8'd2);
    chk("t3_done", done_b, 1'b1);
    step();
    chk("t3_done_1cyc", done_b, 1'b0);
    chk("t3_match", match_b, 1'b0);

    // 4: stalls before a single all-ones vector
    golden_sig = 16'h001F; num_vectors = 8'd1; start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_hold_sig", sig_b, 16'h0000);
      chk("t4_hold_vc", vc_b, 8'd0);
      chk("t4_hold_busy", busy_b, 1'b1);
      chk("t4_hold_done", done_b, 1'b0);
    end
    dv = 5'h1F; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t4_sig", sig_b, 16'h001F);
    chk("t4_done", done_b, 1'b1);
    step();
    chk("t4_match", match_b, 1'b1);

    // 5: zero-length run, then start ignored in RUN and DONE
    num_vectors = 8'd0; start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("t5_zero_done", done_a, 1'b1);
    chk("t5_zero_sig", sig_a, 16'hFFFF);
    chk("t5_zero_vc", vc_a, 8'd0);
    chk("t5_zero_busy", busy_a, 1'b0);
    step();
    chk("t5_zero_done_off", done_a, 1'b0);
    golden_sig = 16'hCF9F; num_vectors = 8'd2; start_a = 1'b1;
    step();
    chk("t5_busy", busy_a, 1'b1);
    num_vectors = 8'd5; dv = 5'h00; in_valid = 1'b1;
    step();
    chk("t5_sig1", sig_a, 16'hEFDF);
    chk("t5_vc1", vc_a, 8'd1);
    step();
    in_valid = 1'b0;
    chk("t5_sig2", sig_a, 16'hCF9F);
    chk("t5_vc2", vc_a, 8'd2);
    chk("t5_done", done_a, 1'b1);
    step();
    start_a = 1'b0;
    chk("t5_done_off", done_a, 1'b0);
    chk("t5_no_reload_sig", sig_a, 16'hCF9F);
    chk("t5_no_reload_vc", vc_a, 8'd2);
    chk("t5_idle_busy", busy_a, 1'b0);
    chk("t5_match", match_a, 1'b1);

    // 1b: reset mid-run after 3 vectors
    num_vectors = 8'd10; start_a = 1'b1;
    step();
    start_a = 1'b0; dv = 5'h00; in_valid = 1'b1;
    step(); step(); step();
    chk("t1_mid_vc", vc_a, 8'd3);
    in_valid = 1'b0; rst = 1'b1;
    step();
    chk("t1_mid_sig", sig_a, 16'hFFFF);
    chk("t1_mid_vc0", vc_a, 8'd0);
    chk("t1_mid_busy", busy_a, 1'b0);
    chk("t1_mid_done", done_a, 1'b0);
    chk("t1_mid_match", match_a, 1'b0);
    rst = 1'b0;
    step();
    chk("t1_mid_no_done", done_a, 1'b0);

    // 6: clean vs trojan adder response streams
    clean_sig = 16'hFFFF;
    for (int i = 0; i < 16; i++)
      clean_sig = misr(clean_sig, adder(4'(i), 4'((i * 7 + 3) & 15), 1'b0));
    golden_sig = clean_sig;
    run16(1'b0);
    chk("t6_clean_sig", sig_a, clean_sig);
    chk("t6_clean_match", match_a, 1'b1);
    run16(1'b1);
    chk("t6_trojan_differs", (sig_a != clean_sig), 1'b1);
    chk("t6_trojan_match", match_a, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
